// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM stream reader.
package bram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Command, BRAM read-port and output-stream signals of the reader.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// offering side holds valid and its payload stable until that edge.
interface bram_stream_reader_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH:0]   cmd_len;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, rd_data, out_ready,
    output cmd_ready, rd_addr, rd_en, out_valid, out_data, out_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, rd_data, out_ready,
    input  cmd_ready, rd_addr, rd_en, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bram_stream_reader_fifo2_reg.sv
// Two-entry register FIFO; head entry drives dout directly so the output is registered.
module fifo2_reg #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [1:0]       count_o,
  output logic             empty_o,
  output logic             full_o
);
  logic [WIDTH-1:0] head_q, tail_q;
  logic [1:0]       count_q;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign dout_o  = head_q;
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      unique case ({push_i, do_pop})
        2'b10: begin
          if (count_q == 2'd0)      head_q <= din_i;
          else if (count_q == 2'd1) tail_q <= din_i;
          if (count_q != 2'd2) count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            head_q <= din_i;
          end else begin
            head_q <= tail_q;
            tail_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/bram_stream_reader.sv
// Reads cmd_len sequential BRAM words from cmd_addr and streams them out with a last flag.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bram_stream_reader_if.master bus,
  output logic                 busy_o,
  output state_t               state_o
);
  localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  inflight_q, inflight_last_q;
  logic                  issue, pop;
  logic [1:0]            fifo_count;
  logic                  fifo_empty, fifo_full;
  logic [2:0]            pending;
  logic [DATA_WIDTH:0]   fifo_dout;

  assign pop     = bus.out_valid && bus.out_ready;
  assign pending = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  // Words already buffered or on their way must leave room for this one.
  assign issue   = (state_q == READ) && (remaining_q != '0) &&
                   (pending < 3'(BUF_DEPTH)) && !(fifo_full && !pop);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d      = bus.cmd_addr;
          remaining_d = bus.cmd_len;
          if (bus.cmd_len != '0) state_d = READ;
        end
      end
      READ: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && (fifo_empty || (fifo_count == 2'd1 && pop))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == REM_ONE);
    end
  end

  fifo2_reg #(.WIDTH(DATA_WIDTH + 1)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .din_i   ({inflight_last_q, bus.rd_data}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // rd_addr is the address register itself, so it holds whenever nothing is issued.
  assign bus.rd_addr   = addr_q;
  assign bus.rd_en     = issue;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_dout[DATA_WIDTH-1:0];
  assign bus.out_last  = fifo_dout[DATA_WIDTH];
  assign busy_o        = (state_q != IDLE);
  assign state_o       = state_q;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: BRAM model, command driver, scoreboard monitor.
module tb_bram_stream_reader;
  import bram_reader_pkg::*;

  localparam int AW = 6;
  localparam int DW = 8;

  logic   clk;
  logic   rst_n;
  logic   busy;
  state_t dbg_state;

  bram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy_o  (busy),
    .state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // BRAM model: synchronous read, one cycle latency, no enable
  logic [DW-1:0] ram [64];
  always @(posedge clk) bus.rd_data <= ram[bus.rd_addr];

  // scoreboard state
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int n_pop = 0;
  int hs_cyc = 0;
  int ready_cyc = 0;
  int first_valid_cyc = -1;
  int outstanding = 0;
  bit stall_q = 0;
  logic [DW:0] stall_word;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks: called just after a rising edge
  task automatic send_cmd(input int a, input int n);
    bit ok;
    int waited;
    logic [AW-1:0] ad;
    ok = 0;
    waited = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 6'(a);
    bus.cmd_len   = 7'(n);
    while (!ok && waited < 500) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1;
        hs_cyc = cyc;
        first_valid_cyc = -1;
        for (int j = 0; j < n; j++) begin
          ad = 6'(a + j);
          addr_exp_q.push_back(ad);
          exp_q.push_back({(j == n - 1), ram[ad]});
        end
      end
      @(posedge clk);
      #1;
      waited++;
    end
    bus.cmd_valid = 1'b0;
    if (!ok) check("cmd_handshake_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        done = 1;
        ready_cyc = cyc;
      end
    end
    if (!done) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // monitor: pops expected queues whenever the DUT issues a read or a word leaves
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      addr_exp_q.delete();
      outstanding = 0;
      stall_q = 0;
    end else begin
      if (bus.rd_en) begin
        outstanding++;
        if (addr_exp_q.size() == 0) check("rd_en_unexpected", 1, 0);
        else check("rd_addr", int'(bus.rd_addr), int'(addr_exp_q.pop_front()));
      end
      if (stall_q) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_word", int'({bus.out_last, bus.out_data}), int'(stall_word));
      end
      stall_q    = bus.out_valid && !bus.out_ready;
      stall_word = {bus.out_last, bus.out_data};
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        outstanding--;
        n_pop++;
        if (exp_q.size() == 0) check("out_unexpected", 1, 0);
        else check("out_word", int'({bus.out_last, bus.out_data}), int'(exp_q.pop_front()));
      end
      n_cmp++;
      if (outstanding > 2) begin
        n_fail++;
        $display("FAIL outstanding: got %0d words issued but not popped, limit 2 (cycle %0d)",
                 outstanding, cyc);
      end
    end
  end

  int base;
  bit reached;

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'(i + 16);
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", int'(bus.cmd_ready), 1);
    check("reset_rd_en", int'(bus.rd_en), 0);
    check("reset_rd_addr", int'(bus.rd_addr), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_data", int'(bus.out_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_state", int'(dbg_state), int'(IDLE));
    @(posedge clk);
    #1;

    // basic: words 0x15..0x18, first valid cycle 3, ready back cycle 7
    send_cmd(5, 4);
    wait_idle(100);
    check("basic_first_valid_cyc", first_valid_cyc - hs_cyc, 3);
    check("basic_ready_cyc", ready_cyc - hs_cyc, 7);

    // wrap: rd_addr 62, 63, 0, 1
    send_cmd(62, 4);
    wait_idle(100);

    // zero length: no reads, no output, ready in cycle 1
    base = n_pop;
    send_cmd(9, 0);
    wait_idle(100);
    check("len0_ready_cyc", ready_cyc - hs_cyc, 1);
    repeat (4) @(posedge clk);
    #1;
    check("len0_words", n_pop - base, 0);

    // full depth at full rate: 64 words, ready back at cycle 67
    base = n_pop;
    send_cmd(0, 64);
    wait_idle(200);
    check("full_words", n_pop - base, 64);
    check("full_ready_cyc", ready_cyc - hs_cyc, 67);

    // backpressure with a 10-cycle stall
    base = n_pop;
    bus.out_ready = 1'b0;
    send_cmd(20, 8);
    for (int i = 0; i < 60; i++) begin
      if (i >= 3 && i < 13) bus.out_ready = 1'b0;
      else bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_idle(100);
    check("bp_words", n_pop - base, 8);

    // reset after three words of a ten-word command
    base = n_pop;
    send_cmd(10, 10);
    reached = 0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk);
      if (n_pop - base >= 3) reached = 1;
    end
    if (!reached) check("midreset_wait_timeout", 0, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_cmd_ready", int'(bus.cmd_ready), 1);
    check("midreset_rd_en", int'(bus.rd_en), 0);
    check("midreset_rd_addr", int'(bus.rd_addr), 0);
    check("midreset_out_valid", int'(bus.out_valid), 0);
    check("midreset_out_data", int'(bus.out_data), 0);
    check("midreset_out_last", int'(bus.out_last), 0);
    check("midreset_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = n_pop;
    send_cmd(0, 2);
    wait_idle(100);
    check("postreset_words", n_pop - base, 2);

    // back-to-back: second command waits until the first drains
    base = n_pop;
    send_cmd(30, 3);
    begin
      int first_hs;
      first_hs = hs_cyc;
      send_cmd(40, 3);
      check("b2b_second_hs_cyc", hs_cyc - first_hs, 6);
    end
    wait_idle(100);
    check("b2b_words", n_pop - base, 6);

    repeat (3) @(posedge clk);
    #1;
    check("final_exp_empty", exp_q.size(), 0);
    check("final_addr_exp_empty", addr_exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
